// File: rtl/dynamic_scan_n_if.sv
// Display-scanner bus: packed digit codes, per-digit dp/mask requests in,
// shared code bus, decimal point, active-low digit enables and frame pulse out.
interface dynamic_scan_n_if #(
    parameter int DIGITS = 4,
    parameter int DW     = 4
);
    logic [DIGITS*DW-1:0] digits;
    logic [DIGITS-1:0]    dp_in;
    logic [DIGITS-1:0]    mask;
    logic [DW-1:0]        seg;
    logic                 dp;
    logic [DIGITS-1:0]    enable;
    logic                 frame_start;

    modport master (
        output digits, dp_in, mask,
        input  seg, dp, enable, frame_start
    );

    modport slave (
        input  digits, dp_in, mask,
        output seg, dp, enable, frame_start
    );
endinterface

// File: rtl/dynamic_scan_n.sv
// Time-multiplexed display scanner: prescaled slots, dead-time blank, frame snapshot.
// Leading-zero blanking is built only when DYNSCAN_LZB_EN is defined.
module dynamic_scan_n #(
    parameter int DIGITS = 4,
    parameter int DW     = 4,
    parameter int DIV    = 50000,
    parameter int BLANK  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dynamic_scan_n_if.slave  bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW = $clog2(DIGITS);

    logic [PW-1:0]        pcnt;
    logic [SW-1:0]        slot;
    logic                 started;
    logic [DIGITS*DW-1:0] sh_dig;
    logic [DIGITS-1:0]    sh_dp;
    logic [DIGITS-1:0]    sh_mask;

    logic [DW-1:0]        sel_dig;
    logic                 sel_dp;
    logic                 sel_mask;
    logic                 supp_sel;
    logic                 dark;
    logic [DIGITS-1:0]    en_nxt;
    logic                 pcnt_wrap;

    logic [DW-1:0]        seg_p1;
    logic                 dp_p1;
    logic [DIGITS-1:0]    enable_p1;
    logic                 frame_start_p1;

    assign pcnt_wrap = (pcnt == PW'(DIV - 1));

    always_comb begin
        sel_dig  = '0;
        sel_dp   = 1'b0;
        sel_mask = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (slot == SW'(k)) begin
                sel_dig  = sh_dig[k*DW +: DW];
                sel_dp   = sh_dp[k];
                sel_mask = sh_mask[k];
            end
        end
    end

`ifdef DYNSCAN_LZB_EN
    // A digit is a leading zero when it and every digit to its left are zero.
    logic zrun;
    always_comb begin
        zrun     = 1'b1;
        supp_sel = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zrun = zrun && (sh_dig[k*DW +: DW] == '0);
            if ((slot == SW'(k)) && zrun)
                supp_sel = 1'b1;
        end
    end
`else
    assign supp_sel = 1'b0;
`endif

    always_comb begin
        dark = (int'(pcnt) < BLANK) || sel_mask || supp_sel;
        for (int k = 0; k < DIGITS; k++)
            en_nxt[k] = dark || (slot != SW'(k));
    end

    // Stage p1: the first edge after reset only takes the snapshot, so the
    // first registered slot already shows fresh data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started        <= 1'b0;
            pcnt           <= '0;
            slot           <= SW'(DIGITS - 1);
            sh_dig         <= '0;
            sh_dp          <= '0;
            sh_mask        <= '0;
            seg_p1         <= '0;
            dp_p1          <= 1'b0;
            enable_p1      <= '1;
            frame_start_p1 <= 1'b0;
        end else if (!started) begin
            started <= 1'b1;
            sh_dig  <= bus.digits;
            sh_dp   <= bus.dp_in;
            sh_mask <= bus.mask;
        end else begin
            if (pcnt_wrap) begin
                pcnt <= '0;
                if (slot == '0) begin
                    slot    <= SW'(DIGITS - 1);
                    sh_dig  <= bus.digits;
                    sh_dp   <= bus.dp_in;
                    sh_mask <= bus.mask;
                end else begin
                    slot <= slot - SW'(1);
                end
            end else begin
                pcnt <= pcnt + PW'(1);
            end
            seg_p1         <= sel_dig;
            dp_p1          <= sel_dp && !dark;
            enable_p1      <= en_nxt;
            frame_start_p1 <= (slot == SW'(DIGITS - 1)) && (pcnt == '0);
        end
    end

    assign bus.seg         = seg_p1;
    assign bus.dp          = dp_p1;
    assign bus.enable      = enable_p1;
    assign bus.frame_start = frame_start_p1;
endmodule

// File: tb/tb_dynamic_scan_n.sv
// Directed bench for dynamic_scan_n: two instances (BLANK=1 and BLANK=0) fed the
// same inputs; leading-zero expectations follow DYNSCAN_LZB_EN.
module tb_dynamic_scan_n;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  mask;

    int vectors = 0;
    int miscompares = 0;

`ifdef DYNSCAN_LZB_EN
    localparam logic [3:0] LIT_0050 = 4'b0011;
    localparam logic [3:0] LIT_0000 = 4'b0001;
`else
    localparam logic [3:0] LIT_0050 = 4'b1111;
    localparam logic [3:0] LIT_0000 = 4'b1111;
`endif

    dynamic_scan_n_if #(.DIGITS(4), .DW(4)) bus0 ();
    dynamic_scan_n_if #(.DIGITS(4), .DW(4)) bus1 ();

    assign bus0.digits = digits;
    assign bus0.dp_in  = dp_in;
    assign bus0.mask   = mask;
    assign bus1.digits = digits;
    assign bus1.dp_in  = dp_in;
    assign bus1.mask   = mask;

    dynamic_scan_n #(.DIGITS(4), .DW(4), .DIV(4), .BLANK(1)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    dynamic_scan_n #(.DIGITS(4), .DW(4), .DIV(4), .BLANK(0)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string where);
        chk({where, " u0.enable"}, 32'(bus0.enable), 32'hF);
        chk({where, " u0.seg"}, 32'(bus0.seg), 32'h0);
        chk({where, " u0.dp"}, 32'(bus0.dp), 32'h0);
        chk({where, " u0.frame_start"}, 32'(bus0.frame_start), 32'h0);
        chk({where, " u1.enable"}, 32'(bus1.enable), 32'hF);
        chk({where, " u1.frame_start"}, 32'(bus1.frame_start), 32'h0);
    endtask

    // Entered on the sample point of a frame's first output cycle; leaves on the
    // first output cycle of the following frame. eseg nibble k / lit[k] / edp[k]
    // describe digit k as it should appear in this frame.
    task automatic check_frame(input string name, input logic [15:0] eseg,
                               input logic [3:0] lit, input logic [3:0] edp);
        logic [3:0] sel;
        logic [3:0] en0;
        logic [3:0] en1;
        string      t;
        for (int s = 3; s >= 0; s--) begin
            for (int c = 0; c < 4; c++) begin
                sel = ~(4'b0001 << s);
                en0 = (lit[s] && c >= 1) ? sel : 4'b1111;
                en1 = lit[s] ? sel : 4'b1111;
                t = $sformatf("%s s%0d c%0d", name, s, c);
                chk({t, " u0.enable"}, 32'(bus0.enable), 32'(en0));
                chk({t, " u0.seg"}, 32'(bus0.seg), 32'(eseg[s*4 +: 4]));
                chk({t, " u0.dp"}, 32'(bus0.dp), 32'(edp[s] && en0 != 4'hF));
                chk({t, " u0.frame_start"}, 32'(bus0.frame_start), 32'(s == 3 && c == 0));
                chk({t, " u1.enable"}, 32'(bus1.enable), 32'(en1));
                chk({t, " u1.seg"}, 32'(bus1.seg), 32'(eseg[s*4 +: 4]));
                chk({t, " u1.dp"}, 32'(bus1.dp), 32'(edp[s] && en1 != 4'hF));
                chk({t, " u1.frame_start"}, 32'(bus1.frame_start), 32'(s == 3 && c == 0));
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        digits = 16'h1234;
        dp_in  = 4'b0000;
        mask   = 4'b0000;
        #12;
        chk_reset_state("reset");

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_state("snapshot edge");
        @(posedge clk);
        @(negedge clk);

        check_frame("F1", 16'h1234, 4'b1111, 4'b0000);
        digits = 16'h5678;
        check_frame("F2", 16'h1234, 4'b1111, 4'b0000);
        mask  = 4'b0100;
        dp_in = 4'b0110;
        check_frame("F3", 16'h5678, 4'b1111, 4'b0000);
        digits = 16'h0050;
        mask   = 4'b0000;
        dp_in  = 4'b0000;
        check_frame("F4", 16'h5678, 4'b1011, 4'b0110);
        digits = 16'h0000;
        check_frame("F5", 16'h0050, LIT_0050, 4'b0000);
        check_frame("F6", 16'h0000, LIT_0000, 4'b0000);

        // Move into digit 0's lit window, then pull reset between clock edges.
        repeat (13) @(posedge clk);
        #2;
        chk("pre-reset u0.enable", 32'(bus0.enable), 32'hE);
        chk("pre-reset u1.enable", 32'(bus1.enable), 32'hE);
        rst_n = 1'b0;
        #1;
        chk_reset_state("async reset");
        digits = 16'h9A0C;
        dp_in  = 4'b1000;
        @(negedge clk);
        chk_reset_state("held reset");
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_state("restart snapshot edge");
        @(posedge clk);
        @(negedge clk);
        check_frame("R1", 16'h9A0C, 4'b1111, 4'b1000);
        check_frame("R2", 16'h9A0C, 4'b1111, 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dynamic_scan_n.md
# dynamic_scan_n

Parametrised time-multiplexed display scanner driving N common-anode digit enables and a shared segment/code bus. It sits between the display-value logic (counters, state display) and the board's digit-select/decoder pins. It adds the following behaviour:
- a built-in prescaler, so the scan rate is set by a parameter rather than by the input clock;
- a dead-time (ghosting) blank at the start of every digit slot;
- per-digit decimal point and mask inputs;
- frame-synchronous snapshot of all inputs, so a digit never shows a mixture of old and new values;
- optional leading-zero suppression.

## Interface
- `DIGITS`, default 4: number of digits scanned; legal range 2..16.
- `DW`, default 4: code width per digit (BCD/hex into an external decoder).
- `DIV`, default 50000: clk cycles per digit slot; must be at least 2.
- `BLANK`, default 2: dead-time cycles at the start of each slot, with all enables off; must satisfy 0 <= BLANK < DIV.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `digits`, in, DIGITS*DW: packed digit codes; digit k is `digits[k*DW +: DW]`; digit DIGITS-1 is the leftmost.
- `dp_in`, in, DIGITS: decimal point request per digit, 1 = on.
- `mask`, in, DIGITS: 1 = force that digit dark.
- `seg`, out, DW: code for the currently selected digit.
- `dp`, out, 1: decimal point for the current digit, active-high.
- `enable`, out, DIGITS: digit enables, active-low; bit k drives digit k.
- `frame_start`, out, 1: one-cycle pulse on the first cycle of each frame.

## Operation
- **Prescaler `pcnt`:** counts 0..DIV-1 and wraps.
- **Slot index `slot`:** decrements on the wrap of `pcnt`. The order is DIGITS-1, DIGITS-2, …, 0, then back to DIGITS-1.
- **Shadow registers `sh_dig`, `sh_dp`, `sh_mask`:**
  - Loaded from the inputs at the frame boundary, i.e. on the edge where `pcnt`==DIV-1 and `slot`==0.
  - Also loaded on the first edge after reset release.
  - Input changes at any other time have no effect until the next frame.
- **Registered outputs:** computed from the current `pcnt`, `slot` and shadow values.
  - `seg` = `sh_dig[slot]` and `dp` = `sh_dp[slot]`. Both are always driven, including during blank.
  - `enable` = all ones if `pcnt` < BLANK, or if `sh_mask[slot]`==1, or if the digit is suppressed (see Configuration).
  - Otherwise `enable` has only bit `slot` low.
  - Whenever `enable` is all ones, `dp` is forced to 0.
- **`frame_start`:** registered; high for exactly the one cycle in which the outputs first reflect `slot`==DIGITS-1, `pcnt`==0.
- **Reset values:**
  - `pcnt`=0, `slot`=DIGITS-1, all shadows 0.
  - `seg`=0, `dp`=0, `enable`=all ones, `frame_start`=0.
- **Reset mid-frame:** outputs go to their reset values immediately, asynchronously. Scanning restarts from digit DIGITS-1 with a fresh snapshot, and no partial slot is resumed.

## Timing
- Output latency: one clk from `pcnt`/`slot` state to pins.
- Frame length: DIGITS*DIV cycles. Each digit is lit for DIV-BLANK cycles per frame.
- The first `frame_start` after reset release occurs on the second rising edge after release. It is the registered pulse for the state `slot`==DIGITS-1, `pcnt`==0.
- Frame period: subsequent `frame_start` pulses are spaced exactly DIGITS*DIV cycles apart.
- Input-to-display latency:
  - An input change is displayed at the next frame.
  - Worst case is DIGITS*DIV+1 cycles.
  - Setup is relative to the frame-boundary edge.
- Enable overlap: two enable bits are never low in the same cycle. At BLANK=0, adjacent slots switch on a single edge with no all-ones cycle in between.

## Configuration
- **Macro:** `DYNSCAN_LZB_EN`, leading-zero blanking.
- **Defined:** digit k (k>0) is suppressed when `sh_dig[j]`==0 for every j >= k. Digit 0 is never suppressed. A suppressed digit keeps `enable` all ones for its whole slot and `dp`=0, even if `sh_dp[k]`=1.
- **Undefined:** no suppression logic is generated, and zero digits display normally.

## Test plan
All scenarios use DIGITS=4, DW=4, DIV=4, BLANK=1 unless stated.

1. **Reset state:** hold `rst_n`=0 → `enable`=4'b1111, `seg`=0, `dp`=0, `frame_start`=0.
   - Pulse `rst_n` low mid-slot → outputs return to these values without waiting for a clk edge.
2. **Scan order:** `digits`=16'h1234, release reset → `frame_start` pulse; then, one slot each:
   - `enable`=1111 (blank), then 0111 with `seg`=1;
   - 1111, then 1011 with `seg`=2;
   - 1111, then 1101 with `seg`=3;
   - 1111, then 1110 with `seg`=4.
   - Next `frame_start` follows 16 cycles after the first.
3. **Snapshot:** change `digits` to 16'h5678 mid-frame → the current frame still shows 1,2,3,4; the next frame shows 5,6,7,8.
4. **Mask and decimal point:**
   - `mask`=4'b0100, `dp_in`=4'b0110 → digit 2 is dark for its whole slot with `dp`=0; digit 1 is lit with `dp`=1.
   - BLANK=0 → no all-ones cycles between slots and never two enable bits low.
5. **Leading-zero blanking (DYNSCAN_LZB_EN):**
   - `digits`=16'h0050 → digits 3 and 2 dark; digits 1 and 0 lit with `seg`=5 and 0.
   - `digits`=16'h0000 → only digit 0 lit with `seg`=0.
   - Without the macro → all four digits lit.
